rd_return_scheduler: RTL

- Pairs read data returned by NUM_CH backend channel controllers with the frontend req_id of each original read request, and returns {id, data} to the frontend on one response port.
- Keeps one in-order ID queue per channel, filled at read-issue time.
- Shares the single response port between channels with round-robin arbitration.
- Sits between the global command dispatcher, the per-channel backend controllers and the frontend read-response path.

---
 rtl/frontend_command_definition_pkg.sv | 17 +
 rtl/rrs_rr_arbiter.sv | 38 +++
 rtl/rd_return_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/frontend_command_definition_pkg.sv
// rtl/frontend_command_definition_pkg.sv - frontend command types and read return scheduler defaults
package frontend_command_definition_pkg;

  typedef logic [7:0] req_id_t;

  localparam int RRS_NUM_CH        = 4;
  localparam int RRS_ID_DEPTH_LOG2 = 4;
  localparam int RRS_DATA_W        = 128;

  typedef logic [$clog2(RRS_NUM_CH)-1:0] rrs_ch_t;

  typedef struct packed {
    req_id_t                 id;
    logic [RRS_DATA_W-1:0]   data;
  } rrs_rsp_t;

endpackage

// File: rtl/rrs_rr_arbiter.sv
// rtl/rrs_rr_arbiter.sv - round-robin arbiter; search starts at the pointer, which then moves past the winner
module rrs_rr_arbiter #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NUM_CH-1:0] i_req,
  input  logic              i_en,
  output logic [NUM_CH-1:0] o_grant,
  output logic [CH_W-1:0]   o_grant_idx,
  output logic              o_grant_valid
);

  logic [CH_W-1:0] r_ptr;
  logic [CH_W-1:0] w_idx;

  always_comb begin
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_idx         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = r_ptr + CH_W'(i);
      if (i_en && i_req[w_idx] && !o_grant_valid) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = w_idx;
      end
    end
    if (o_grant_valid) o_grant[o_grant_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)           r_ptr <= '0;
    else if (o_grant_valid) r_ptr <= o_grant_idx + CH_W'(1);
  end

endmodule

// File: rtl/rd_return_scheduler.sv
// rtl/rd_return_scheduler.sv - pairs per-channel read data with queued frontend IDs onto one response port
// Optional global issue-order return: define RRS_INORDER_EN.
module rd_return_scheduler
  import frontend_command_definition_pkg::*;
#(
  parameter  int NUM_CH        = RRS_NUM_CH,
  parameter  int ID_DEPTH_LOG2 = RRS_ID_DEPTH_LOG2,
  parameter  int DATA_W        = RRS_DATA_W,
  localparam int CH_W          = $clog2(NUM_CH),
  localparam int OUT_W         = ID_DEPTH_LOG2 + 1 + CH_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_issue_valid,
  input  logic [CH_W-1:0]          i_issue_ch,
  input  req_id_t                  i_issue_id,
  output logic                     o_issue_ready,
  input  logic [NUM_CH-1:0]        i_ret_valid,
  input  logic [NUM_CH*DATA_W-1:0] i_ret_data,
  output logic [NUM_CH-1:0]        o_ret_ready,
  output logic                     o_rsp_valid,
  output req_id_t                  o_rsp_id,
  output logic [DATA_W-1:0]        o_rsp_data,
  input  logic                     i_rsp_ready,
  output logic [OUT_W-1:0]         o_outstanding,
  output logic                     o_err_orphan
);

  localparam int PW    = ID_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << ID_DEPTH_LOG2;

  req_id_t           r_idq  [NUM_CH][DEPTH];
  logic [PW-1:0]     r_wptr [NUM_CH];
  logic [PW-1:0]     r_rptr [NUM_CH];
  logic              r_rsp_valid;
  req_id_t           r_rsp_id;
  logic [DATA_W-1:0] r_rsp_data;
  logic [OUT_W-1:0]  r_outstanding;
  logic              r_err;

  logic [NUM_CH-1:0] w_full, w_empty, w_elig, w_orphan, w_grant;
  logic [CH_W-1:0]   w_grant_idx;
  logic              w_grant_valid;
  logic              w_push, w_load, w_ord_room;

  always_comb begin
    w_full  = '0;
    w_empty = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_full[c]  = (r_wptr[c][PW-1] != r_rptr[c][PW-1]) &&
                   (r_wptr[c][PW-2:0] == r_rptr[c][PW-2:0]);
      w_empty[c] = (r_wptr[c] == r_rptr[c]);
    end
  end

  // Readiness comes from registered state only, so a same-cycle pop never frees a slot early.
  assign o_issue_ready = !w_full[i_issue_ch] && w_ord_room;
  assign w_push        = i_issue_valid && o_issue_ready;
  assign w_load        = !r_rsp_valid || i_rsp_ready;

  always_comb begin
    w_elig   = '0;
    w_orphan = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_elig[c]   = i_ret_valid[c] && !w_empty[c];
      w_orphan[c] = i_ret_valid[c] && w_empty[c] &&
                    !(w_push && (i_issue_ch == CH_W'(c)));
    end
  end

`ifdef RRS_INORDER_EN
  localparam int OW = ID_DEPTH_LOG2 + CH_W + 1;

  logic [CH_W-1:0] r_ordq [NUM_CH*DEPTH];
  logic [OW-1:0]   r_owptr, r_orptr;
  logic            w_ord_empty;
  logic [CH_W-1:0] w_head;

  assign w_ord_empty = (r_owptr == r_orptr);
  assign w_ord_room  = !((r_owptr[OW-1] != r_orptr[OW-1]) &&
                         (r_owptr[OW-2:0] == r_orptr[OW-2:0]));
  assign w_head      = r_ordq[r_orptr[OW-2:0]];

  // Only the channel that was issued to earliest may return.
  always_comb begin
    w_grant       = '0;
    w_grant_idx   = w_head;
    w_grant_valid = w_load && !w_ord_empty && w_elig[w_head];
    if (w_grant_valid) w_grant[w_head] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_ordq[r_owptr[OW-2:0]] <= i_issue_ch;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owptr <= '0;
      r_orptr <= '0;
    end else begin
      if (w_push)        r_owptr <= r_owptr + OW'(1);
      if (w_grant_valid) r_orptr <= r_orptr + OW'(1);
    end
  end
`else
  assign w_ord_room = 1'b1;

  rrs_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_req         (w_elig),
    .i_en          (w_load),
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );
`endif

  // Orphans are acknowledged and dropped without taking the response slot.
  assign o_ret_ready = w_grant | w_orphan;

  always_ff @(posedge i_clk) begin
    if (w_push) r_idq[i_issue_ch][r_wptr[i_issue_ch][PW-2:0]] <= i_issue_id;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_push && (i_issue_ch == CH_W'(c))) r_wptr[c] <= r_wptr[c] + PW'(1);
        if (w_grant[c])                         r_rptr[c] <= r_rptr[c] + PW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_data    <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_grant_valid) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_idq[w_grant_idx][r_rptr[w_grant_idx][PW-2:0]];
        r_rsp_data  <= i_ret_data[w_grant_idx*DATA_W +: DATA_W];
      end else if (i_rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
      r_outstanding <= r_outstanding + {{(OUT_W-1){1'b0}}, w_push}
                                     - {{(OUT_W-1){1'b0}}, w_grant_valid};
      r_err         <= r_err | (|w_orphan);
    end
  end

  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_id      = r_rsp_id;
  assign o_rsp_data    = r_rsp_data;
  assign o_outstanding = r_outstanding;
  assign o_err_orphan  = r_err;

endmodule
